tsn_tx_pri_dispatch: RTL and testbench
======================================

TSN_TX_PRI_DISPATCH -- requirements
Module: tsn_tx_pri_dispatch

Interface
REQ-001 Parameter PORT_FIFO_PRI_NUM, default 8: number of priority FIFOs/queues (max 8); index 7 is highest priority.
REQ-002 Parameter DATA_WIDTH, default 8: beat width of FIFO data and MAC TX AXIS data.
REQ-003 Parameter IFG_CYCLES, default 12: idle gap cycles enforced after each frame's last beat (legal range 0..255).
REQ-004 i_clk  in  1  250 MHz clock.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_queue  in  N  eligible-queue vector from the Qav/shaper stage (1 = eligible).
REQ-007 i_queue_vld  in  1  single-cycle strobe qualifying i_queue.
REQ-008 o_scheduing_rst  out  N  one-hot granted queue, returned to the shaper.
REQ-009 o_scheduing_rst_vld  out  1  single-cycle strobe qualifying o_scheduing_rst.
REQ-010 i_fifo_empty  in  N  per-priority FWFT FIFO empty flags.
REQ-011 i_fifo_rdata  in  N*DATA_WIDTH  per-priority FWFT head data, queue k at bits [k*DW +: DW].
REQ-012 i_fifo_rlast  in  N  per-priority head-beat end-of-frame marker.
REQ-013 o_fifo_rd_en  out  N  pop strobe, at most one bit set.
REQ-014 o_mac_tx_axis_data  out  DATA_WIDTH; o_mac_tx_axis_valid out 1; o_mac_tx_axis_last out 1; o_mac_tx_axis_user out 16 = {8'd0, zero-extended grant one-hot}.
REQ-015 i_mac_tx_axis_ready  in  1  MAC sink ready.

Function
REQ-016 FSM states IDLE, SEND, GAP; reset state IDLE.
REQ-017 Any i_queue_vld with i_queue != 0, in any state, loads pending register r_pend <= i_queue and sets r_pend_vld; a later strobe overwrites (latest wins); i_queue_vld with i_queue == 0 clears r_pend_vld.
REQ-018 IDLE: if i_queue_vld with nonzero i_queue this cycle, arbitrate on i_queue directly; else if r_pend_vld, arbitrate on r_pend; otherwise stay IDLE.
REQ-019 Arbitration is strict priority: grant = highest set index; grant latched in r_grant; r_pend_vld cleared on consumption; next state SEND.
REQ-020 o_scheduing_rst = r_grant and o_scheduing_rst_vld = 1 for exactly the first SEND cycle (one cycle after the arbitration cycle); both 0 otherwise.
REQ-021 SEND: o_fifo_rd_en[g] = 1 (combinational) when i_fifo_empty[g] == 0 and output register is free (o_mac_tx_axis_valid == 0 or i_mac_tx_axis_ready == 1); the beat is loaded into the output register on that edge with valid = 1, last = i_fifo_rlast[g].
REQ-022 AXIS rule: data/last/user held stable while valid && !ready; valid deasserts only after acceptance with no replacement beat.
REQ-023 Underrun (FIFO g empty mid-frame): no pop; valid drops after current beat accepted; frame resumes when data arrives; no timeout.
REQ-024 No pop after the beat with rlast = 1 is loaded; state moves to GAP on acceptance (valid && ready && last).
REQ-025 GAP: 8-bit counter runs IFG_CYCLES cycles then IDLE; IFG_CYCLES = 0 moves to IDLE on the next cycle.
REQ-026 Grant is not changed mid-frame regardless of i_queue activity; strobes during SEND/GAP only update r_pend.
REQ-027 Throughput: back-to-back beats at 1 beat/cycle when FIFO non-empty and ready held high.
REQ-028 Eligibility of a queue whose FIFO is empty at grant time is still honoured (wait in SEND per REQ-023).

Reset
REQ-029 On i_rst asserted, immediately: state IDLE, r_grant 0, r_pend/r_pend_vld 0, GAP counter 0, all outputs 0, including mid-frame; no partial frame resumes after reset release.

Verification
REQ-030 i_queue = 8'b0010_0100 strobed in IDLE at T -> o_scheduing_rst = 8'b0010_0000, vld at T+1; o_fifo_rd_en[5] first high at T+1; first valid beat at T+2, user = 16'h0020.
REQ-031 3-beat frame on queue 2, ready constant 1 -> 3 consecutive valid beats, last on third; then exactly IFG_CYCLES (12) cycles in GAP with no rd_en before IDLE.
REQ-032 Ready toggled 1/0 during a 4-beat frame -> data/last stable while stalled; exactly 4 pops, 4 accepted beats, no duplicates.
REQ-033 Strobe i_queue = 8'h01 then 8'h80 during SEND of queue 3 -> frame completes on queue 3; after GAP, grant = 8'h80 from r_pend.
REQ-034 Assert i_rst on 2nd beat of a 5-beat frame -> all outputs 0 same cycle; after release and new strobe 8'h02, grant 8'h02, no stale beat emitted.

Source files
------------

// File: rtl/tsn_tx_pri_dispatch.sv
// TSN transmit priority dispatcher.
// Takes the eligible-queue vector from the shaper and grants the highest
// eligible priority. It then streams that queue's FWFT FIFO frame to the MAC
// over AXI-Stream and enforces an inter-frame gap before the next grant.
module tsn_tx_pri_dispatch #(
  parameter int PORT_FIFO_PRI_NUM = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int IFG_CYCLES        = 12
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [PORT_FIFO_PRI_NUM-1:0]            i_queue,
  input  logic                                    i_queue_vld,
  output logic [PORT_FIFO_PRI_NUM-1:0]            o_scheduing_rst,
  output logic                                    o_scheduing_rst_vld,
  input  logic [PORT_FIFO_PRI_NUM-1:0]            i_fifo_empty,
  input  logic [PORT_FIFO_PRI_NUM*DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic [PORT_FIFO_PRI_NUM-1:0]            i_fifo_rlast,
  output logic [PORT_FIFO_PRI_NUM-1:0]            o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0]                   o_mac_tx_axis_data,
  output logic                                    o_mac_tx_axis_valid,
  output logic                                    o_mac_tx_axis_last,
  output logic [15:0]                             o_mac_tx_axis_user,
  input  logic                                    i_mac_tx_axis_ready
);

  localparam int N = PORT_FIFO_PRI_NUM;
  localparam logic [8:0] IFG9 = 9'(IFG_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t                  state, state_nxt;
  logic [N-1:0]            r_pend;
  logic                    r_pend_vld;
  logic [N-1:0]            r_grant;
  logic [7:0]              r_gap_cnt;
  logic                    r_last_popped;

  logic [N-1:0]            arb_src;
  logic [N-1:0]            arb_onehot;
  logic                    arb_req;
  logic                    arb_take;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_empty;
  logic                    head_last;
  logic [7:0]              grant8;
  logic                    out_free;
  logic                    pop;
  logic                    accept_last;
  logic                    gap_done;

  // Arbitration source (live strobe beats pending request) and strict-priority pick
  always_comb begin
    arb_src    = '0;
    arb_req    = 1'b0;
    arb_onehot = '0;
    if (i_queue_vld && (|i_queue)) begin
      arb_src = i_queue;
      arb_req = 1'b1;
    end else if (r_pend_vld) begin
      arb_src = r_pend;
      arb_req = 1'b1;
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (arb_src[k]) begin
        arb_onehot    = '0;
        arb_onehot[k] = 1'b1;
      end
    end
  end

  // Head-of-FIFO view of the granted queue, plus the zero-extended grant for user
  always_comb begin
    head_data  = '0;
    head_empty = 1'b1;
    head_last  = 1'b0;
    grant8     = '0;
    grant8[N-1:0] = r_grant;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_grant[k]) begin
        head_data  = i_fifo_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        head_empty = i_fifo_empty[k];
        head_last  = i_fifo_rlast[k];
      end
    end
  end

  assign arb_take    = (state == ST_IDLE) && arb_req;
  assign out_free    = !o_mac_tx_axis_valid || i_mac_tx_axis_ready;
  assign pop         = (state == ST_SEND) && !r_last_popped && !head_empty && out_free;
  assign accept_last = o_mac_tx_axis_valid && i_mac_tx_axis_ready && o_mac_tx_axis_last;
  assign gap_done    = ({1'b0, r_gap_cnt} + 9'd1) >= IFG9;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_req) state_nxt = ST_SEND;
      ST_SEND: if (accept_last) state_nxt = ST_GAP;
      ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: pop the granted FIFO only while a frame is in flight
  always_comb begin
    o_fifo_rd_en = '0;
    if (pop) o_fifo_rd_en = r_grant;
  end

  // Pending request, grant, scheduler feedback and gap counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend              <= '0;
      r_pend_vld          <= 1'b0;
      r_grant             <= '0;
      r_gap_cnt           <= '0;
      r_last_popped       <= 1'b0;
      o_scheduing_rst     <= '0;
      o_scheduing_rst_vld <= 1'b0;
    end else begin
      // A grant consumes the request; otherwise strobes only refresh r_pend
      if (arb_take) begin
        r_pend_vld <= 1'b0;
      end else if (i_queue_vld) begin
        if (|i_queue) begin
          r_pend     <= i_queue;
          r_pend_vld <= 1'b1;
        end else begin
          r_pend_vld <= 1'b0;
        end
      end
      if (arb_take) r_grant <= arb_onehot;
      o_scheduing_rst     <= arb_take ? arb_onehot : '0;
      o_scheduing_rst_vld <= arb_take;
      if (arb_take)              r_last_popped <= 1'b0;
      else if (pop && head_last) r_last_popped <= 1'b1;
      r_gap_cnt <= (state == ST_GAP) ? r_gap_cnt + 8'd1 : '0;
    end
  end

  // AXIS output register: load on pop, drop valid only after acceptance
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mac_tx_axis_data  <= '0;
      o_mac_tx_axis_valid <= 1'b0;
      o_mac_tx_axis_last  <= 1'b0;
      o_mac_tx_axis_user  <= '0;
    end else if (pop) begin
      o_mac_tx_axis_data  <= head_data;
      o_mac_tx_axis_valid <= 1'b1;
      o_mac_tx_axis_last  <= head_last;
      o_mac_tx_axis_user  <= {8'd0, grant8};
    end else if (i_mac_tx_axis_ready) begin
      o_mac_tx_axis_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tsn_tx_pri_dispatch.sv
// Directed testbench for tsn_tx_pri_dispatch with behavioural FWFT FIFOs.
module tb_tsn_tx_pri_dispatch;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int IFG = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_queue;
  logic            i_queue_vld;
  logic [N-1:0]    sched_rst;
  logic            sched_vld;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_rdata;
  logic [N-1:0]    fifo_rlast;
  logic [N-1:0]    rd_en;
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tlast;
  logic [15:0]     tuser;
  logic            tready;

  int nassert = 0;
  int nfail   = 0;

  always #5 clk = ~clk;

  tsn_tx_pri_dispatch #(
    .PORT_FIFO_PRI_NUM(N),
    .DATA_WIDTH(DW),
    .IFG_CYCLES(IFG)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_queue(i_queue),
    .i_queue_vld(i_queue_vld),
    .o_scheduing_rst(sched_rst),
    .o_scheduing_rst_vld(sched_vld),
    .i_fifo_empty(fifo_empty),
    .i_fifo_rdata(fifo_rdata),
    .i_fifo_rlast(fifo_rlast),
    .o_fifo_rd_en(rd_en),
    .o_mac_tx_axis_data(tdata),
    .o_mac_tx_axis_valid(tvalid),
    .o_mac_tx_axis_last(tlast),
    .o_mac_tx_axis_user(tuser),
    .i_mac_tx_axis_ready(tready)
  );

  // Behavioural FWFT FIFOs: {last, data} entries, 32 deep per queue
  logic [8:0] mem [N][32];
  int         wp [N];
  int         rp [N];

  initial begin
    for (int k = 0; k < N; k++) begin
      rp[k] = 0;
      wp[k] = 0;
      for (int e = 0; e < 32; e++) mem[k][e] = '0;
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_rdata = '0;
    fifo_rlast = '0;
    for (int k = 0; k < N; k++) begin
      fifo_empty[k]           = (rp[k] == wp[k]);
      fifo_rdata[k*DW +: DW]  = mem[k][rp[k] % 32][7:0];
      fifo_rlast[k]           = mem[k][rp[k] % 32][8];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++)
      if (rd_en[k] && rp[k] != wp[k]) rp[k] <= rp[k] + 1;
  end

  // Monitor: pop/accept counts, accepted-beat log, AXIS stall stability
  int         npop = 0;
  int         nacc = 0;
  int         nstall_err = 0;
  int         nrd_err = 0;
  logic [8:0] log_b [256];
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;
  logic [15:0] pu = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (|rd_en) npop <= npop + 1;
      if (!$onehot0(rd_en)) nrd_err <= nrd_err + 1;
      if (tvalid && tready) begin
        log_b[nacc % 256] <= {tlast, tdata};
        nacc <= nacc + 1;
      end
      if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl || tuser !== pu))
        nstall_err <= nstall_err + 1;
      pv <= tvalid; pr <= tready; pd <= tdata; pl <= tlast; pu <= tuser;
    end else begin
      pv <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int q, input logic [7:0] d, input logic l);
    mem[q][wp[q] % 32] = {l, d};
    wp[q] = wp[q] + 1;
  endtask

  // Called at the negedge showing a frame's last beat; strobes q one cycle later
  // and measures negedges until the resulting grant appears.
  task automatic measure_gap(input logic [7:0] q, input string tag);
    int   j;
    logic bad;
    j   = 0;
    bad = 1'b0;
    while (j < 40) begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        i_queue = q; i_queue_vld = 1'b1;
      end else begin
        i_queue = '0; i_queue_vld = 1'b0;
      end
      if (sched_vld) break;
      if ((|rd_en) || tvalid) bad = 1'b1;
    end
    i_queue = '0; i_queue_vld = 1'b0;
    chk({tag, "_len"}, j, IFG + 2);
    chk({tag, "_quiet"}, {31'd0, bad}, 0);
  endtask

  task automatic wait_acc(input int target, input string tag);
    int c;
    c = 0;
    while (nacc < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, {31'd0, (nacc >= target)}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base_acc, base_pop, c;
    logic bad;

    rst = 1'b1; i_queue = '0; i_queue_vld = 1'b0; tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_sched", sched_rst, 0);
    chk("rst_sched_vld", sched_vld, 0);
    chk("rst_valid", tvalid, 0);
    chk("rst_data_last_user", {tdata, tlast, tuser}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Strobe 0x24 in IDLE: queue 5 wins
    push(5, 8'h51, 1'b1);
    push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    i_queue = 8'h24; i_queue_vld = 1'b1;
    @(negedge clk);
    i_queue = '0; i_queue_vld = 1'b0;
    chk("t30_sched", sched_rst, 8'h20);
    chk("t30_sched_vld", sched_vld, 1);
    chk("t30_rd_en", rd_en, 8'h20);
    @(negedge clk);
    chk("t30_sched_vld_drop", sched_vld, 0);
    chk("t30_beat", {tvalid, tlast, tdata}, {1'b1, 1'b1, 8'h51});
    chk("t30_user", tuser, 16'h0020);
    chk("t30_no_pop_after_last", rd_en, 0);

    // Gap after queue 5, then queue 2 three-beat frame back to back
    measure_gap(8'h04, "gap_q5");
    chk("t31_sched", sched_rst, 8'h04);
    chk("t31_rd_en", rd_en, 8'h04);
    @(negedge clk);
    chk("t31_beat0", {tvalid, tlast, tdata}, {1'b1, 1'b0, 8'h21});
    @(negedge clk);
    chk("t31_beat1", {tvalid, tlast, tdata}, {1'b1, 1'b0, 8'h22});
    @(negedge clk);
    chk("t31_beat2", {tvalid, tlast, tdata}, {1'b1, 1'b1, 8'h23});
    push(0, 8'h0A, 1'b1);
    measure_gap(8'h01, "gap_q2");
    chk("t31_next_sched", sched_rst, 8'h01);
    @(negedge clk);
    chk("t31_q0_beat", {tvalid, tlast, tdata, tuser}, {1'b1, 1'b1, 8'h0A, 16'h0001});
    repeat (IFG + 3) @(negedge clk);

    // Four-beat frame on queue 6 with ready toggling
    for (int i = 0; i < 4; i++) push(6, 8'h61 + 8'(i), (i == 3));
    base_acc = nacc; base_pop = npop;
    i_queue = 8'h40; i_queue_vld = 1'b1;
    c = 0;
    while (nacc < base_acc + 4 && c < 60) begin
      @(negedge clk);
      i_queue = '0; i_queue_vld = 1'b0;
      tready = (c % 2 == 1);
      c++;
    end
    tready = 1'b1;
    repeat (IFG + 3) @(negedge clk);
    chk("t32_pops", npop - base_pop, 4);
    chk("t32_accepts", nacc - base_acc, 4);
    chk("t32_stall_stable", nstall_err, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t32_beat%0d", i), log_b[(base_acc + i) % 256], {(i == 3), 8'h61 + 8'(i)});

    // Granted queue 4 is empty: wait, underrun mid-frame, resume
    i_queue = 8'h10; i_queue_vld = 1'b1;
    @(negedge clk);
    i_queue = '0; i_queue_vld = 1'b0;
    chk("t23_sched", sched_rst, 8'h10);
    chk("t23_no_pop_empty", rd_en, 0);
    repeat (3) @(negedge clk);
    chk("t23_wait_valid", tvalid, 0);
    push(4, 8'h41, 1'b0);
    #1;
    chk("t23_pop_on_data", rd_en, 8'h10);
    @(negedge clk);
    chk("t23_beat0", {tvalid, tlast, tdata}, {1'b1, 1'b0, 8'h41});
    @(negedge clk);
    chk("t23_underrun", {tvalid, rd_en}, 0);
    push(4, 8'h42, 1'b1);
    @(negedge clk);
    chk("t23_beat1", {tvalid, tlast, tdata}, {1'b1, 1'b1, 8'h42});
    repeat (IFG + 3) @(negedge clk);

    // Strobes 0x01 then 0x80 during queue 3 frame: latest pending wins afterwards
    for (int i = 0; i < 4; i++) push(3, 8'h31 + 8'(i), (i == 3));
    push(7, 8'h71, 1'b1);
    push(0, 8'h0B, 1'b1);
    base_acc = nacc;
    i_queue = 8'h08; i_queue_vld = 1'b1;
    @(negedge clk);
    chk("t33_sched", sched_rst, 8'h08);
    i_queue = 8'h01;
    @(negedge clk);
    i_queue = 8'h80;
    @(negedge clk);
    i_queue = '0; i_queue_vld = 1'b0;
    wait_acc(base_acc + 4, "t33_frame");
    for (int i = 0; i < 4; i++)
      chk($sformatf("t33_beat%0d", i), log_b[(base_acc + i) % 256], {(i == 3), 8'h31 + 8'(i)});
    c = 0;
    while (!sched_vld && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("t33_pend_sched", {sched_vld, sched_rst}, {1'b1, 8'h80});
    @(negedge clk);
    chk("t33_q7_beat", {tvalid, tdata, tuser}, {1'b1, 8'h71, 16'h0080});
    repeat (IFG + 3) @(negedge clk);

    // Reset on second beat of a five-beat frame
    for (int i = 0; i < 5; i++) push(5, 8'h91 + 8'(i), (i == 4));
    i_queue = 8'h20; i_queue_vld = 1'b1;
    @(negedge clk);
    i_queue = '0; i_queue_vld = 1'b0;
    @(negedge clk);
    chk("t34_beat0", tdata, 8'h91);
    @(negedge clk);
    chk("t34_beat1", {tvalid, tdata}, {1'b1, 8'h92});
    rst = 1'b1;
    #1;
    chk("t34_rst_axis", {tvalid, tlast, tdata, tuser}, 0);
    chk("t34_rst_rd_en", rd_en, 0);
    chk("t34_rst_sched", {sched_vld, sched_rst}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (tvalid || (|rd_en) || sched_vld) bad = 1'b1;
    end
    chk("t34_no_resume", {31'd0, bad}, 0);
    push(1, 8'h12, 1'b1);
    i_queue = 8'h02; i_queue_vld = 1'b1;
    @(negedge clk);
    i_queue = '0; i_queue_vld = 1'b0;
    chk("t34_sched", {sched_vld, sched_rst}, {1'b1, 8'h02});
    chk("t34_rd_en", rd_en, 8'h02);
    @(negedge clk);
    chk("t34_new_beat", {tvalid, tlast, tdata, tuser}, {1'b1, 1'b1, 8'h12, 16'h0002});
    chk("t34_onehot_rd_en", nrd_err, 0);
    repeat (IFG + 3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
